// File: rtl/fp_cvt_sched.sv
// Shared float-to-int32 conversion unit: round-robin issue from NREQ requesters onto
// one single- and one double-precision converter, results buffered in a credit-protected FIFO.

module fp_cvt_unit #(
  parameter bit DBL = 1'b0,
  parameter int W   = DBL ? 64 : 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         rdy,
  output logic [31:0]  dout,
  output logic         overflow,
  output logic         invalid_op
);
  localparam int EXPW  = DBL ? 11 : 8;
  localparam int FRACW = DBL ? 52 : 23;
  localparam int BIAS  = DBL ? 1023 : 127;
  localparam int LAT   = 6;

  logic             sign;
  logic [EXPW-1:0]  expf;
  logic [FRACW-1:0] frac;
  logic [63:0]      mant;
  logic [31:0]      mag;
  int               e;
  logic [31:0]      cvt_res;
  logic             cvt_ovf;
  logic             cvt_inv;

  always_comb begin
    sign    = din[W-1];
    expf    = din[FRACW +: EXPW];
    frac    = din[FRACW-1:0];
    mant    = 64'({1'b1, frac});
    e       = int'(expf) - BIAS;
    mag     = '0;
    cvt_res = '0;
    cvt_ovf = 1'b0;
    cvt_inv = 1'b0;
    if (&expf) begin
      cvt_inv = 1'b1;
      cvt_res = (sign && frac == '0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < 0) begin
      cvt_res = '0;
    end else if (e >= 31) begin
      // -2^31 is the one magnitude at this exponent that still fits
      cvt_res = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      cvt_ovf = !(sign && e == 31 && frac == '0);
    end else begin
      mag     = (e >= FRACW) ? 32'(mant << (e - FRACW)) : 32'(mant >> (FRACW - e));
      cvt_res = sign ? -mag : mag;
    end
  end

  logic [LAT-1:0] vld_reg;
  logic [33:0]    res_reg [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg <= '0;
      for (int i = 0; i < LAT; i++) res_reg[i] <= '0;
    end else begin
      vld_reg[0] <= en;
      res_reg[0] <= {cvt_inv, cvt_ovf, cvt_res};
      for (int i = 1; i < LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        res_reg[i] <= res_reg[i-1];
      end
    end
  end

  assign rdy = vld_reg[LAT-1];
  assign {invalid_op, overflow, dout} = res_reg[LAT-1];
endmodule

module fp_cvt_sched #(
  parameter int NREQ  = 4,
  parameter int TAGW  = 5,
  parameter int DEPTH = 8,
  parameter int SRCW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_dbl,
  input  logic [NREQ*64-1:0]   req_data,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic                 res_overflow,
  output logic                 res_invalid,
  output logic [TAGW-1:0]      res_tag,
  output logic [SRCW-1:0]      res_src,
  output logic                 busy,
  output logic                 err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PIPE = 6;

  typedef struct packed {
    logic            valid;
    logic            dbl;
    logic [TAGW-1:0] tag;
    logic [SRCW-1:0] src;
  } trk_t;

  typedef struct packed {
    logic [31:0]     data;
    logic            ovf;
    logic            inv;
    logic [TAGW-1:0] tag;
    logic [SRCW-1:0] src;
  } res_t;

  logic [SRCW-1:0] rr_ptr_reg;
  logic [CW-1:0]   fifo_cnt_reg;
  logic [CW-1:0]   inflight_cnt_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic            err_reg;
  trk_t            trk_reg [PIPE];
  res_t            mem [DEPTH];

  logic [SRCW-1:0] grant;
  logic            found;
  logic            credit_ok;
  logic            accept;
  logic [63:0]     op;
  logic            op_dbl;
  logic [TAGW-1:0] op_tag;
  logic            sp_en, dp_en;
  logic            sp_rdy, dp_rdy;
  logic [31:0]     sp_dout, dp_dout;
  logic            sp_ovf, dp_ovf, sp_inv, dp_inv;
  logic            push, do_push, pop, full, rdy_bad;
  res_t            cmp;
  res_t            head;
  int              idx;

  // Credit counts only registered state, so a pop frees its slot one cycle later.
  assign credit_ok = ({1'b0, fifo_cnt_reg} + {1'b0, inflight_cnt_reg}) < (CW+1)'(DEPTH);

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = SRCW'(idx);
      end
    end
  end

  assign accept    = found && credit_ok && !rst;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign op        = req_data[64*grant +: 64];
  assign op_dbl    = req_dbl[grant];
  assign op_tag    = req_tag[TAGW*grant +: TAGW];
  assign sp_en     = accept && !op_dbl;
  assign dp_en     = accept && op_dbl;

  fp_cvt_unit #(.DBL(1'b0)) u_sp (
    .clk(clk), .rst(rst), .en(sp_en), .din(op[31:0]),
    .rdy(sp_rdy), .dout(sp_dout), .overflow(sp_ovf), .invalid_op(sp_inv)
  );

  fp_cvt_unit #(.DBL(1'b1)) u_dp (
    .clk(clk), .rst(rst), .en(dp_en), .din(op),
    .rdy(dp_rdy), .dout(dp_dout), .overflow(dp_ovf), .invalid_op(dp_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) trk_reg[i] <= '0;
    end else begin
      trk_reg[0] <= {accept, op_dbl, op_tag, grant};
      for (int i = 1; i < PIPE; i++) trk_reg[i] <= trk_reg[i-1];
    end
  end

  // Last tracking entry lines up with the converter output registers.
  always_comb begin
    cmp.data = trk_reg[PIPE-1].dbl ? dp_dout : sp_dout;
    cmp.ovf  = trk_reg[PIPE-1].dbl ? dp_ovf  : sp_ovf;
    cmp.inv  = trk_reg[PIPE-1].dbl ? dp_inv  : sp_inv;
    cmp.tag  = trk_reg[PIPE-1].tag;
    cmp.src  = trk_reg[PIPE-1].src;
  end

  assign push    = trk_reg[PIPE-1].valid;
  assign full    = (fifo_cnt_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign pop     = (fifo_cnt_reg != '0) && res_ready;
  assign rdy_bad = push ? (trk_reg[PIPE-1].dbl ? !dp_rdy : !sp_rdy) : (sp_rdy || dp_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg       <= '0;
      inflight_cnt_reg <= '0;
      fifo_cnt_reg     <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      err_reg          <= 1'b0;
    end else begin
      if (accept) rr_ptr_reg <= (grant == SRCW'(NREQ-1)) ? '0 : grant + 1'b1;
      inflight_cnt_reg <= inflight_cnt_reg + CW'(accept) - CW'(push);
      fifo_cnt_reg     <= fifo_cnt_reg + CW'(do_push) - CW'(pop);
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (rdy_bad || (push && full)) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= cmp;
  end

  assign head         = mem[rd_ptr_reg];
  assign res_valid    = (fifo_cnt_reg != '0);
  assign res_data     = head.data;
  assign res_overflow = head.ovf;
  assign res_invalid  = head.inv;
  assign res_tag      = head.tag;
  assign res_src      = head.src;
  assign busy         = (inflight_cnt_reg != '0) || (fifo_cnt_reg != '0);
  assign err          = err_reg;
endmodule

// File: tb/tb_fp_cvt_sched.sv
// Scoreboard bench for fp_cvt_sched: expected results are queued at issue and
// compared in order as the result FIFO drains.

module tb_fp_cvt_sched;
  localparam int NREQ = 4, TAGW = 5, DEPTH = 8, SRCW = 2, NTBL = 13;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_dbl = '0;
  logic [NREQ*64-1:0]   req_data = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [31:0]          res_data;
  logic                 res_overflow, res_invalid;
  logic [TAGW-1:0]      res_tag;
  logic [SRCW-1:0]      res_src;
  logic                 busy, err;

  always #5 clk = ~clk;

  fp_cvt_sched #(.NREQ(NREQ), .TAGW(TAGW), .DEPTH(DEPTH), .SRCW(SRCW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dbl(req_dbl),
    .req_data(req_data), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_invalid(res_invalid),
    .res_tag(res_tag), .res_src(res_src), .busy(busy), .err(err)
  );

  // Operand table with hand-derived int32 results (truncate toward zero, saturate).
  logic [63:0] tbl_op [NTBL] = '{
    64'h0000_0000_4049_0FDB, 64'h0000_0000_C020_0000, 64'hBFF0_0000_0000_0000,
    64'h4202_A05F_2000_0000, 64'h0000_0000_7FC0_0000, 64'h0000_0000_3F00_0000,
    64'h0000_0000_CF00_0000, 64'h0000_0000_4F00_0000, 64'h4059_0000_0000_0000,
    64'hC05E_DD2F_1A9F_BE77, 64'h0000_0000_FF80_0000, 64'h0000_0000_4B00_0001,
    64'h41DF_FFFF_FFC0_0000};
  logic [31:0] tbl_res [NTBL] = '{
    32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
    32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0064, 32'hFFFF_FF85,
    32'h8000_0000, 32'h0080_0001, 32'h7FFF_FFFF};
  bit tbl_dbl [NTBL] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
  bit tbl_ovf [NTBL] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  bit tbl_inv [NTBL] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

  typedef struct {
    logic [31:0]     data;
    logic            ovf;
    logic            inv;
    logic [TAGW-1:0] tag;
    logic [SRCW-1:0] src;
    int              step;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_tests = 0, n_fail = 0;
  int   step_no = 0, acc_total = 0, acc_step = 0, model_ptr = 0;
  bit   chk_lat = 1'b0;
  logic want_ready = 1'b0;
  bit              cur_valid [NREQ];
  bit              cont      [NREQ];
  int              cur_op    [NREQ];
  logic [TAGW-1:0] cur_tag   [NREQ];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", name, got, exp, step_no);
    end
  endtask

  // Singles carry junk in the upper half so only bits [31:0] may matter.
  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      logic [63:0] v;
      v = tbl_op[cur_op[i]];
      req_valid[i] = cur_valid[i];
      req_dbl[i]   = tbl_dbl[cur_op[i]];
      req_data[64*i +: 64] = tbl_dbl[cur_op[i]] ? v : {32'hA5A5_0000 | 32'(i), v[31:0]};
      req_tag[TAGW*i +: TAGW] = cur_tag[i];
    end
    res_ready = want_ready;
  endtask

  task automatic monitor();
    int   g;
    int   exp_g;
    exp_t e;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        $display("[TB] result src=%0d tag=%0d data=0x%08h ovf=%0b inv=%0b",
                 res_src, res_tag, res_data, res_overflow, res_invalid);
        check("res_data", 64'(res_data), 64'(e.data));
        check("res_overflow", 64'(res_overflow), 64'(e.ovf));
        check("res_invalid", 64'(res_invalid), 64'(e.inv));
        check("res_tag", 64'(res_tag), 64'(e.tag));
        check("res_src", 64'(res_src), 64'(e.src));
        if (chk_lat) check("latency", 64'(step_no - e.step), 64'd7);
      end
    end
    acc_step = 0;
    if (!rst && (req_valid & req_ready) != '0) begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      check("ready_onehot", 64'($countones(req_ready)), 64'd1);
      exp_g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (model_ptr + k) % NREQ;
        if (exp_g < 0 && req_valid[j]) exp_g = j;
      end
      check("grant", 64'(g), 64'(exp_g));
      model_ptr = (g + 1) % NREQ;
      e.data = tbl_res[cur_op[g]];
      e.ovf  = tbl_ovf[cur_op[g]];
      e.inv  = tbl_inv[cur_op[g]];
      e.tag  = cur_tag[g];
      e.src  = SRCW'(g);
      e.step = step_no;
      sb.push_back(e);
      grant_log.push_back(g);
      acc_total++;
      acc_step = 1;
      $display("[TB] issue src=%0d tag=%0d op=0x%016h", g, cur_tag[g], tbl_op[cur_op[g]]);
      if (cont[g]) begin
        cur_op[g]  = (cur_op[g] + 1) % NTBL;
        cur_tag[g] = cur_tag[g] + 1'b1;
      end else begin
        cur_valid[g] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_bus();
    #2;
    step_no++;
    monitor();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cur_valid[i] = 1'b1;
      cont[i]      = 1'b0;
      cur_op[i]    = 0;
      cur_tag[i]   = '0;
    end
    drive_bus();
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    for (int i = 0; i < NREQ; i++) cur_valid[i] = 1'b0;
    drive_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    sb.delete();
    grant_log.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    want_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int acc0;

    // Single-precision pi from requester 1, tag 5.
    do_reset();
    want_ready = 1'b1;
    chk_lat    = 1'b1;
    cur_op[1] = 0; cur_tag[1] = 5'd5; cur_valid[1] = 1'b1;
    step();
    check("single_accept", 64'(acc_step), 64'd1);
    check("single_grant", 64'(grant_log[0]), 64'd1);
    drain(30);

    // Mixed precision, back-to-back, covering the rest of the table.
    do_reset();
    want_ready = 1'b1;
    chk_lat    = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        cur_op[i]    = 1 + 4*b + i;
        cur_tag[i]   = TAGW'(10 + 4*b + i);
        cur_valid[i] = 1'b1;
      end
      for (int s = 0; s < NREQ; s++) begin
        step();
        check("mixed_accept", 64'(acc_step), 64'd1);
      end
    end
    drain(30);
    check("mixed_err", 64'(err), 64'd0);

    // All requesters continuously valid: strict rotation from requester 0.
    do_reset();
    want_ready = 1'b1;
    chk_lat    = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cur_op[i] = 3*i; cur_tag[i] = TAGW'(i*8); cur_valid[i] = 1'b1; cont[i] = 1'b1;
    end
    acc0 = acc_total;
    repeat (16) step();
    check("rr_accepts", 64'(acc_total - acc0), 64'd16);
    for (int k = 0; k < 16 && k < grant_log.size(); k++)
      check("rr_sequence", 64'(grant_log[k]), 64'(k % NREQ));
    for (int i = 0; i < NREQ; i++) begin cur_valid[i] = 1'b0; cont[i] = 1'b0; end
    drain(30);

    // Back-pressure: credits cap issue at DEPTH, one pop frees one slot a cycle later.
    do_reset();
    want_ready = 1'b0;
    chk_lat    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cur_op[i] = i; cur_tag[i] = TAGW'(i + 20); cur_valid[i] = 1'b1; cont[i] = 1'b1;
    end
    acc0 = acc_total;
    repeat (20) step();
    check("bp_accepts", 64'(acc_total - acc0), 64'(DEPTH));
    check("bp_req_ready", 64'(req_ready), 64'd0);
    check("bp_err", 64'(err), 64'd0);
    want_ready = 1'b1;
    step();
    check("bp_pop_no_accept", 64'(acc_step), 64'd0);
    want_ready = 1'b0;
    step();
    check("bp_refill_accept", 64'(acc_step), 64'd1);
    repeat (4) step();
    check("bp_accepts_after_pop", 64'(acc_total - acc0), 64'(DEPTH + 1));
    for (int i = 0; i < NREQ; i++) begin cur_valid[i] = 1'b0; cont[i] = 1'b0; end
    drain(60);
    check("bp_err_end", 64'(err), 64'd0);

    // Reset while results are both buffered and in flight.
    do_reset();
    want_ready = 1'b0;
    chk_lat    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_op[i] = i; cur_tag[i] = TAGW'(i + 1); cur_valid[i] = 1'b1;
    end
    repeat (8) step();
    check("pre_rst_res_valid", 64'(res_valid), 64'd1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    want_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      check("post_rst_res_valid", 64'(res_valid), 64'd0);
    end
    check("post_rst_err", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_cvt_sched.md
Name: fp_cvt_sched

Overview:
- Shared float-to-integer conversion unit for the multithreaded FPU.
- Round-robin arbitrates NREQ requesters (thread/issue slots) onto one internal single-precision converter and one internal double-precision converter. Exactly one operation issues per cycle.
- Tracks in-flight operations with a tag shift pipeline. Completed results are buffered in a credit-protected result FIFO, so downstream back-pressure never drops a result, even though the converter pipes cannot stall.

Parameters:
- NREQ, 4, number of requesters (≥2).
- TAGW, 5, requester-supplied tag width.
- DEPTH, 8, result FIFO entries (power of 2, ≥2).
- SRCW, 2, width of requester index (=clog2(NREQ)).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_dbl  in  NREQ  1 = double operand (64-bit), 0 = single (bits [31:0] used)
- req_data  in  NREQ*64  operands, requester i at [64i+63:64i]
- req_tag  in  NREQ*TAGW  tags, requester i at [TAGW*i+TAGW-1:TAGW*i]
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  32  signed integer result (truncated toward zero)
- res_overflow  out  1  converter overflow flag
- res_invalid  out  1  converter invalid-op flag (NaN/Inf)
- res_tag  out  TAGW  tag of the result
- res_src  out  SRCW  requester index that issued the result
- busy  out  1  in-flight count ≠0 or FIFO non-empty
- err  out  1  sticky: converter rdy disagreed with tracked valid

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset is also routed to both converters.
- Reset values: res_valid=0, err=0, busy=0, FIFO empty, in-flight count=0, tracking pipe cleared, RR pointer=0 (requester 0 highest priority). req_ready=0 while rst is high.
- Credit: issue is allowed iff fifo_cnt + inflight_cnt < DEPTH, using registered counts. A pop frees its credit from the next cycle, not the same cycle.
- Arbitration: when issue is allowed, grant the first requester with valid, starting from the RR pointer. req_ready[g]=1 combinationally for that requester only. Accept = req_valid[g] & req_ready[g].
  - On accept, the pointer becomes g+1 mod NREQ.
  - With no accept, the pointer holds.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Issue: on accept, drive the single-converter en if req_dbl=0, otherwise the double-converter en, with the operand, in the same cycle. Never both.
- Tracking pipe: 6 entries of {valid, dbl, tag, src}. Entry 0 loads at the accept edge n; entries shift every cycle. Entry 5 aligns with the converter outputs after edge n+5.
- Completion: when entry 5 is valid, take dout/overflow/invalid_op from the unit selected by entry 5's dbl. Push {data, ovf, inv, tag, src} into the FIFO at edge n+6.
  - res_valid is high from edge n+6. Minimum latency from accept to result is 6 cycles.
- err: set when entry 5 is valid and the selected unit's rdy≠1. Also set when entry 5 is invalid and either unit's rdy=1. Cleared only by reset.
- inflight_cnt: +1 on accept, −1 on completion. Both in the same cycle leaves it unchanged.
- FIFO: pop on res_valid & res_ready. Push and pop in the same cycle are both honoured. Overflow is impossible by credit; any push while full also sets err.
  - Ordering is strict issue order. Results of different precision never collide, because both units share the same latency.
- Outputs res_* are driven from the FIFO head. Their values are don't-care when res_valid=0.
- Reset mid-operation: all in-flight and buffered results are discarded. No result emerges after release.

Test Plan:
- Single 0x40490FDB (3.14159), requester 1, tag 5, res_ready=1. Required: res_valid after edge n+6, res_data=0x00000003, ovf=0, inv=0, tag=5, src=1.
- Mixed back-to-back issue on consecutive cycles:
  - 0xC0200000 (-2.5f) → 0xFFFFFFFE.
  - double 0xBFF0000000000000 (-1.0) → 0xFFFFFFFF.
  - double 0x4202A05F20000000 (1e10) → 0x7FFFFFFF, ovf=1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, inv=1.
  - Required: results in issue order on consecutive cycles.
- All 4 requesters continuously valid, res_ready=1. Required: grant sequence 0,1,2,3,0,1,… with one accept per cycle.
- res_ready=0 with continuous requests. Required: exactly 8 accepts, then req_ready=0. One pop → one more accept the following cycle. Nothing is lost, and err=0.
- 3 operations issued, then rst pulsed mid-flight. Required: res_valid=0 and busy=0 immediately; no result within 10 cycles after release; err=0.
